// File: rtl/fxp_pkg.sv
// Shared signed fixed-point definitions for the array_prod dot-product block.
// Holds the default Qn.m format, the operand/product types, the FSM state type
// and the saturating narrowing helper used when ARRAY_PROD_SATURATE_EN is defined.
package fxp_pkg;

    localparam int unsigned QN_DEF = 6;
    localparam int unsigned QM_DEF = 11;

    // Total signed word width for a Qn.m format (sign bit included)
    function automatic int unsigned bitwidth(input int unsigned qn, input int unsigned qm);
        return qn + qm + 1;
    endfunction

    localparam int unsigned FXP_W = bitwidth(QN_DEF, QM_DEF);

    typedef logic signed [FXP_W-1:0]   fxp_t;
    typedef logic signed [2*FXP_W-1:0] prod_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    // The caller keeps the low w bits of the returned value.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                      input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/array_prod_if.sv
// Vector/result bus of the array_prod dot-product block.
// master drives the two operand vectors, slave returns dataReady/result.
interface array_prod_if #(
    parameter int unsigned VEC_W    = 144,
    parameter int unsigned BITWIDTH = 18
);
    logic [VEC_W-1:0]    vecA;
    logic [VEC_W-1:0]    vecB;
    logic                dataReady;
    logic [BITWIDTH-1:0] result;

    modport master (
        output vecA,
        output vecB,
        input  dataReady,
        input  result
    );

    modport slave (
        input  vecA,
        input  vecB,
        output dataReady,
        output result
    );
endinterface

// File: rtl/fxp_mac.sv
// Registered signed multiply followed by a registered accumulate.
// clr_i synchronously empties both the product and accumulator registers.
module fxp_mac #(
    parameter int unsigned W     = 18,
    parameter int unsigned ACC_W = 39
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    mul_en_i,
    input  logic                    acc_en_i,
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*W-1:0]   prod_q;
    logic signed [2*W-1:0]   prod_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Next product / running sum; clear has priority over both enables
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (clr_i) begin
            prod_d = '0;
            acc_d  = '0;
        end else begin
            if (mul_en_i) begin
                prod_d = (2*W)'(a_i) * (2*W)'(b_i);
            end
            if (acc_en_i) begin
                acc_d = acc_q + ACC_W'(prod_q);
            end
        end
    end

    // Product and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/array_prod.sv
// Sequential signed Qn.m dot product of two NUM_ELEMS-element vectors, one MAC
// per clock, started by releasing reset. Result appears with dataReady on the
// (NUM_ELEMS+2)th rising edge after release and is held until the next reset.
// Optional build macro: ARRAY_PROD_SATURATE_EN clamps the narrowed result to the
// signed BITWIDTH range instead of keeping the wrapped low bits.
module array_prod
    import fxp_pkg::*;
#(
    parameter int unsigned NUM_ELEMS = 8,
    parameter int unsigned QN        = QN_DEF,
    parameter int unsigned QM        = QM_DEF
) (
    input  logic         clock,
    input  logic         reset,
    array_prod_if.slave  bus
);

    localparam int unsigned BITWIDTH = bitwidth(QN, QM);
    localparam int unsigned IDX_W    = $clog2(NUM_ELEMS);
    localparam int unsigned ACC_W    = 2*BITWIDTH + $clog2(NUM_ELEMS);

    state_t                   state_q;
    state_t                   state_d;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_d;
    logic [BITWIDTH-1:0]      result_q;
    logic [BITWIDTH-1:0]      result_d;
    logic                     ready_q;
    logic                     ready_d;

    logic                     mul_en_c;
    logic                     acc_en_c;
    logic                     clr_c;
    logic signed [BITWIDTH-1:0] a_sel_c;
    logic signed [BITWIDTH-1:0] b_sel_c;
    logic signed [ACC_W-1:0]  acc_c;
    logic [BITWIDTH-1:0]      narrow_c;

    // Element select: idx walks the packed vectors one element per cycle
    always_comb begin
        a_sel_c = bus.vecA[32'(idx_q) * BITWIDTH +: BITWIDTH];
        b_sel_c = bus.vecB[32'(idx_q) * BITWIDTH +: BITWIDTH];
    end

    fxp_mac #(
        .W     (BITWIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clock),
        .rst_n    (reset),
        .clr_i    (clr_c),
        .mul_en_i (mul_en_c),
        .acc_en_i (acc_en_c),
        .a_i      (a_sel_c),
        .b_i      (b_sel_c),
        .acc_o    (acc_c)
    );

    // Drop the QM fraction bits (floor) and fit the sum into one word
    always_comb begin
`ifdef ARRAY_PROD_SATURATE_EN
        narrow_c = BITWIDTH'(sat_narrow(64'(acc_c >>> QM), BITWIDTH));
`else
        narrow_c = BITWIDTH'(acc_c >>> QM);
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        ready_d  = ready_q;
        mul_en_c = 1'b0;
        acc_en_c = 1'b0;
        clr_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // First edge after release issues element 0
                mul_en_c = 1'b1;
                idx_d    = idx_q + 1'b1;
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                mul_en_c = 1'b1;
                acc_en_c = 1'b1;
                if (idx_q == IDX_W'(NUM_ELEMS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Last product still in flight: one more add
                acc_en_c = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (!ready_q) begin
                    result_d = narrow_c;
                    ready_d  = 1'b1;
                end else begin
                    // Result is latched; park the MAC
                    clr_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.dataReady = ready_q;

endmodule

// File: tb/tb_array_prod.sv
// Bench for array_prod (N=8, Q6.11): directed vectors with hand-computed sums.
// Expected results go into a scoreboard queue at reset release; a monitor pops
// and compares result and latency when dataReady rises.
module tb_array_prod;

    localparam int unsigned N   = 8;
    localparam int unsigned BW  = 18;
    localparam int unsigned VW  = BW * N;
    localparam int          LAT = 10;

    logic clock;
    logic reset;

    array_prod_if #(.VEC_W(VW), .BITWIDTH(BW)) bus ();

    array_prod #(
        .NUM_ELEMS (N),
        .QN        (6),
        .QM        (11)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int edge_cnt = 0;

    logic [BW-1:0] exp_q[$];
    int            rel_q[$];
    logic          prev_rdy = 1'b0;

    always @(posedge clock) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    // Monitor: compare on each rising dataReady
    initial begin
        forever begin
            @(negedge clock);
            if (bus.dataReady === 1'b1 && prev_rdy === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ready", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [BW-1:0] e;
                    int            r;
                    e = exp_q.pop_front();
                    r = rel_q.pop_front();
                    check("result", 32'(bus.result), 32'(e));
                    check("latency", 32'(edge_cnt - r), 32'(LAT));
                end
            end
            prev_rdy = bus.dataReady;
        end
    end

    // One full computation: reset, load vectors, release, wait for dataReady
    task automatic run_case(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [BW-1:0] exp);
        bit seen;
        @(negedge clock);
        reset    = 1'b0;
        bus.vecA = a;
        bus.vecB = b;
        @(negedge clock);
        exp_q.push_back(exp);
        rel_q.push_back(edge_cnt);
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.dataReady === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("ready_timeout", 32'(bus.dataReady), 32'd1);
            exp_q.delete();
            rel_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [BW-1:0] exp_ovf_pos;
        logic [BW-1:0] exp_ovf_neg;
        logic [BW-1:0] held_res;

`ifdef ARRAY_PROD_SATURATE_EN
        exp_ovf_pos = 18'h1FFFF;
        exp_ovf_neg = 18'h20000;
`else
        exp_ovf_pos = 18'h04000;
        exp_ovf_neg = 18'h3C000;
`endif

        reset    = 1'b1;
        bus.vecA = '0;
        bus.vecB = '0;
        #2 reset = 1'b0;
        #1;
        check("reset_ready", 32'(bus.dataReady), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);

        // 1: all ones -> 8.0
        run_case(fill(2048), fill(2048), 18'd16384);

        // 2a: alternating +1/-1 against 0.5 -> 0
        a = '0;
        for (int i = 0; i < int'(N); i++) a[i*BW +: BW] = (i % 2 == 0) ? BW'(2048) : BW'(-2048);
        run_case(a, fill(1024), 18'd0);

        // 2b: single term -2.5 * 3.0 -> -7.5
        a = '0; b = '0;
        a[3*BW +: BW] = BW'(-5120);
        b[3*BW +: BW] = BW'(6144);
        run_case(a, b, 18'h3C400);

        // 3: floor of one-LSB products
        a = '0; b = '0;
        a[0 +: BW] = BW'(1);
        b[0 +: BW] = BW'(1);
        run_case(a, b, 18'd0);
        a[0 +: BW] = BW'(-1);
        run_case(a, b, 18'h3FFFF);

        // 4: overflow on final narrowing
        run_case(fill(63488), fill(63488), exp_ovf_pos);
        run_case(fill(63488), fill(-63488), exp_ovf_neg);

        // Reset while DONE clears outputs without waiting for a clock edge
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("done_reset_ready", 32'(bus.dataReady), 32'd0);
        check("done_reset_result", 32'(bus.result), 32'd0);

        // 5: abort case 1 at the 3rd edge, then rerun it from scratch
        @(negedge clock);
        bus.vecA = fill(2048);
        bus.vecB = fill(2048);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("abort_ready", 32'(bus.dataReady), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        run_case(fill(2048), fill(2048), 18'd16384);

        // 6: inputs wiggle after DONE, outputs must hold
        held_res = bus.result;
        check("hold_base", 32'(held_res), 32'd16384);
        for (int c = 0; c < 20; c++) begin
            bus.vecA = {5{$urandom()}};
            bus.vecB = {5{$urandom()}};
            @(negedge clock);
            check("hold_result", 32'(bus.result), 32'd16384);
            check("hold_ready", 32'(bus.dataReady), 32'd1);
        end

        @(negedge clock);
        if (exp_q.size() != 0) check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
